// File: rtl/cam_frame_capture.sv
// Camera PCLK-domain capture engine: parses the VSYNC/HREF/RGB565 byte stream, converts and clips pixels,
// and drives the frame-buffer write port. Define CAM_CAPTURE_STATS_EN to add frame/line-error counters.
module cam_frame_capture #(
    parameter int unsigned IMG_W     = 176,
    parameter int unsigned IMG_H     = 144,
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned OUT_W     = 8,
    parameter int unsigned BYTE_SWAP = 0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              EN,
    input  logic              CAM_VSYNC,
    input  logic              CAM_HREF,
    input  logic [7:0]        CAM_DATA,
    output logic              W_EN,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic [OUT_W-1:0]  W_DATA,
    output logic              FRAME_DONE,
`ifdef CAM_CAPTURE_STATS_EN
    output logic [15:0]       FRAME_CNT,
    output logic [7:0]        LINE_ERR_CNT,
`endif
    output logic              BUSY
);

    // x/y carry one spare bit so oversize lines/frames saturate instead of wrapping back into range
    localparam int unsigned X_W = $clog2(IMG_W + 1) + 1;
    localparam int unsigned Y_W = $clog2(IMG_H + 1) + 1;

    if (!(OUT_W == 8 || OUT_W == 12 || OUT_W == 16)) begin : g_bad_out_w
        $error("cam_frame_capture: OUT_W must be 8, 12 or 16");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARMED     = 3'd1,
        WAIT_LINE = 3'd2,
        LINE      = 3'd3,
        FRAME_END = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic              vs_q, hr_q;
    logic [7:0]        d_q, b0;
    logic              phase;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ADDR_W-1:0] row_base;

    logic              take_byte_c, pix_done_c, line_end_c, line_abort_c, in_clip_c, frame_done_c;
    logic [15:0]       word_c;

    function automatic logic [OUT_W-1:0] conv(input logic [15:0] w);
        if (OUT_W == 8)       return OUT_W'({w[15:13], w[10:8], w[4:3]});
        else if (OUT_W == 12) return OUT_W'({w[15:12], w[10:7], w[4:1]});
        else                  return OUT_W'(w);
    endfunction

    // state register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    // next-state logic; VSYNC takes priority over HREF everywhere inside a frame
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (EN && vs_q) state_nxt = ARMED;
            ARMED:     if (!vs_q) state_nxt = WAIT_LINE;
            WAIT_LINE: if (vs_q) state_nxt = FRAME_END;
                       else if (hr_q) state_nxt = LINE;
            LINE:      if (vs_q) state_nxt = FRAME_END;
                       else if (!hr_q) state_nxt = WAIT_LINE;
            FRAME_END: state_nxt = EN ? ARMED : IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // byte/pixel/line events derived from the registered camera signals
    always_comb begin
        take_byte_c  = ((state == WAIT_LINE) || (state == LINE)) && hr_q && !vs_q;
        pix_done_c   = take_byte_c && phase;
        line_end_c   = (state == LINE) && !hr_q && !vs_q;
        line_abort_c = (state == LINE) && vs_q;
        word_c       = (BYTE_SWAP != 0) ? {d_q, b0} : {b0, d_q};
        in_clip_c    = (x < X_W'(IMG_W)) && (y < Y_W'(IMG_H));
        frame_done_c = (state_nxt == FRAME_END) && ((x != '0) || (y != '0));
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            vs_q       <= 1'b0;
            hr_q       <= 1'b0;
            d_q        <= '0;
            b0         <= '0;
            phase      <= 1'b0;
            x          <= '0;
            y          <= '0;
            row_base   <= '0;
            W_EN       <= 1'b0;
            W_ADDR     <= '0;
            W_DATA     <= '0;
            FRAME_DONE <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            vs_q       <= CAM_VSYNC;
            hr_q       <= CAM_HREF;
            d_q        <= CAM_DATA;
            BUSY       <= (state_nxt != IDLE);
            FRAME_DONE <= frame_done_c;
            W_EN       <= pix_done_c && in_clip_c;
            if (pix_done_c) begin
                W_ADDR <= row_base + ADDR_W'(x);
                W_DATA <= conv(word_c);
            end

            if ((state == IDLE) || (state == ARMED) || (state == FRAME_END)) begin
                x        <= '0;
                y        <= '0;
                row_base <= '0;
                phase    <= 1'b0;
            end else if (line_end_c) begin
                // empty lines (no completed pixel) do not consume a row
                if (x != '0) begin
                    if (y != '1) y <= y + Y_W'(1);
                    if (y < Y_W'(IMG_H)) row_base <= row_base + ADDR_W'(IMG_W);
                end
                x     <= '0;
                phase <= 1'b0;
            end else if (take_byte_c) begin
                phase <= ~phase;
                if (!phase)        b0 <= d_q;
                else if (x != '1)  x  <= x + X_W'(1);
            end
        end
    end

`ifdef CAM_CAPTURE_STATS_EN
    // frame counter wraps; line-error counter saturates
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            FRAME_CNT    <= '0;
            LINE_ERR_CNT <= '0;
        end else begin
            if (frame_done_c) FRAME_CNT <= FRAME_CNT + 16'd1;
            if (((line_end_c && (x != '0) && (x != X_W'(IMG_W))) || line_abort_c) && (LINE_ERR_CNT != 8'hFF))
                LINE_ERR_CNT <= LINE_ERR_CNT + 8'd1;
        end
    end
`endif

endmodule
